// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetch addresses to a
// synchronous instruction memory and presents each returned instruction to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 12
) (
  input  logic        clk,
  input  logic        zero,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        imem_freeze,
  input  logic [31:0] RI,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_fault,
  output logic [31:0] instr_cnt
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  logic [31:0] pc_q, pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_oob_q, resp_oob_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic stall;
  logic advance;
  logic accept;

  // Decode handshake: dec_valid/dec_instr/dec_pc stay stable while dec_valid is
  // high and dec_ready is low; a transfer happens on any edge with both high.
  assign stall   = resp_valid_q & ~dec_ready;
  assign advance = fetch_en & ~stall & ~redirect_valid;
  assign accept  = resp_valid_q & dec_ready;

  assign imem_freeze = ~advance;
  assign pc_out      = pc_q;
  assign dec_valid   = resp_valid_q;
  assign dec_pc      = resp_pc_q;
  assign dec_instr   = resp_oob_q ? NOP_INSTR : RI;
  assign fetch_fault = fault_q;
  assign instr_cnt   = cnt_q;

  always_comb begin
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    resp_oob_d   = resp_oob_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;

    if (redirect_valid) begin
      // A redirect discards whatever response is in flight or held.
      pc_d         = {redirect_pc[31:2], 2'b00};
      resp_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (fetch_en) begin
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      resp_oob_d   = (pc_q[31:2] >= IMEM_LIMIT);
      pc_d         = pc_q + 32'd4;
    end else begin
      resp_valid_d = 1'b0;
    end

    if (accept) begin
      cnt_d = cnt_q + 32'd1;
      if (resp_oob_q) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (zero) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      resp_oob_q   <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      resp_oob_q   <= resp_oob_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal checks plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_fetch_unit;

  localparam int          WORDS = 12;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        zero = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc_out;
  logic        imem_freeze;
  logic [31:0] RI = 32'd0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;
  logic [31:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] imem [WORDS];

  fetch_unit #(.RESET_PC(32'h00000000), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .zero(zero), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_out(pc_out), .imem_freeze(imem_freeze), .RI(RI),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .fetch_fault(fetch_fault), .instr_cnt(instr_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  initial begin
    for (int i = 0; i < WORDS; i++) imem[i] = 32'h00000093 | (32'(i) << 20);
    imem[0] = 32'h00438393;
    imem[1] = 32'hffe38393;
    imem[2] = 32'h00c40433;
    imem[8] = 32'h00438393;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:2] < 30'(WORDS)) return imem[addr[31:2]];
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) if (!imem_freeze) RI <= mem_word(pc_out);

  // ---------------- model ----------------
  // exp_q holds the byte addresses of responses awaiting decode, oldest first.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc = 32'd0;
  logic        m_fault = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    bit have;
    have = (exp_q.size() != 0);
    if (zero) begin
      exp_q.delete();
      m_pc    = 32'h00000000;
      m_fault = 1'b0;
      m_cnt   = 32'd0;
      m_live  = 1'b1;
    end else if (m_live) begin
      if (have && dec_ready) begin
        m_cnt = m_cnt + 32'd1;
        if (exp_q[0][31:2] >= 30'(WORDS)) m_fault = 1'b1;
      end
      if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFFFFFC;
      end else if (have && !dec_ready) begin
        // held response, nothing moves
      end else if (fetch_en) begin
        exp_q.delete();
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end else begin
        exp_q.delete();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      bit have;
      logic exp_freeze;
      have = (exp_q.size() != 0);
      exp_freeze = ~(fetch_en & ~(have & ~dec_ready) & ~redirect_valid);
      check("m_dec_valid", 32'(dec_valid), 32'(have));
      check("m_pc_out", pc_out, m_pc);
      check("m_fault", 32'(fetch_fault), 32'(m_fault));
      check("m_instr_cnt", instr_cnt, m_cnt);
      check("m_imem_freeze", 32'(imem_freeze), 32'(exp_freeze));
      if (have) begin
        check("m_dec_pc", dec_pc, exp_q[0]);
        check("m_dec_instr", dec_instr,
              (exp_q[0][31:2] < 30'(WORDS)) ? imem[exp_q[0][31:2]] : NOP);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reach_pc4_stalled();
    zero = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    tick(); tick();
    zero = 1'b0;
    tick();
    tick();
    check("pre_dec_pc4", dec_pc, 32'h4);
    dec_ready = 1'b0;
  endtask

  initial begin
    // streaming
    zero = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_cnt", instr_cnt, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    zero = 1'b0;
    tick();
    check("s0_valid", 32'(dec_valid), 32'd1);
    check("s0_pc", dec_pc, 32'h0);
    check("s0_instr", dec_instr, 32'h00438393);
    tick();
    check("s1_pc", dec_pc, 32'h4);
    check("s1_instr", dec_instr, 32'hffe38393);
    tick();
    check("s2_pc", dec_pc, 32'h8);
    check("s2_instr", dec_instr, 32'h00c40433);
    fetch_en = 1'b0;
    tick();
    check("s_cnt3", instr_cnt, 32'd3);
    check("s_idle_valid", 32'(dec_valid), 32'd0);
    check("s_pc_out", pc_out, 32'hC);

    // stall
    reach_pc4_stalled();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc", dec_pc, 32'h4);
      check("st_instr", dec_instr, 32'hffe38393);
      check("st_pc_out", pc_out, 32'h8);
      check("st_freeze", 32'(imem_freeze), 32'd1);
    end
    dec_ready = 1'b1;
    tick();
    check("st_rel_pc", dec_pc, 32'h8);
    check("st_rel_instr", dec_instr, 32'h00c40433);
    check("st_cnt", instr_cnt, 32'd2);

    // redirect while stalled, then misaligned redirect with coincident accept
    reach_pc4_stalled();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    check("rd_flush", 32'(dec_valid), 32'd0);
    check("rd_pc_out", pc_out, 32'h20);
    redirect_valid = 1'b0; dec_ready = 1'b1;
    tick();
    check("rd_pc", dec_pc, 32'h20);
    check("rd_instr", dec_instr, 32'h00438393);
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    check("mis_pc_out", pc_out, 32'h20);
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_cnt", instr_cnt, 32'd2);
    redirect_valid = 1'b0;
    tick(); tick();
    check("mis_sticky", 32'(fetch_fault), 32'd1);
    zero = 1'b1;
    tick();
    check("mis_clear", 32'(fetch_fault), 32'd0);

    // out of range
    zero = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h28;
    tick();
    check("oob_pc_out", pc_out, 32'h28);
    redirect_valid = 1'b0;
    tick();
    check("oob_w10", dec_pc, 32'h28);
    tick();
    check("oob_w11", dec_pc, 32'h2C);
    tick();
    check("oob_pc", dec_pc, 32'h30);
    check("oob_nop", dec_instr, NOP);
    check("oob_nofault", 32'(fetch_fault), 32'd0);
    tick();
    check("oob_fault", 32'(fetch_fault), 32'd1);
    check("oob_cnt", instr_cnt, 32'd3);

    // reset mid-stall with instr_cnt=5
    tick();
    tick();
    dec_ready = 1'b0;
    tick();
    check("mr_cnt5", instr_cnt, 32'd5);
    check("mr_stall_valid", 32'(dec_valid), 32'd1);
    zero = 1'b1;
    tick();
    check("mr_valid", 32'(dec_valid), 32'd0);
    check("mr_cnt", instr_cnt, 32'd0);
    check("mr_pc_out", pc_out, 32'h0);
    zero = 1'b0; dec_ready = 1'b1;
    tick();
    check("mr_first_valid", 32'(dec_valid), 32'd1);
    check("mr_first_pc", dec_pc, 32'h0);

    // reset wins over a simultaneous redirect
    zero = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check("zr_pc_out", pc_out, 32'h0);
    zero = 1'b0; redirect_valid = 1'b0;
    tick();
    check("zr_first_pc", dec_pc, 32'h0);
    check("zr_first_valid", 32'(dec_valid), 32'd1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 12, the number of valid 32-bit words in instruction memory.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port zero, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port fetch_en, input, 1 bit; high permits issuing new fetches.
REQ-006 SHALL have port redirect_valid, input, 1 bit, branch/jump redirect request.
REQ-007 SHALL have port redirect_pc, input, 32 bits, redirect target byte address.
REQ-008 SHALL have port pc_out, output, 32 bits, registered byte address to instruction memory.
REQ-009 SHALL have port imem_freeze, output, 1 bit; high makes instruction memory hold RI.
REQ-010 SHALL have port RI, input, 32 bits, instruction from memory; one-cycle synchronous read latency.
REQ-011 SHALL have port dec_valid, output, 1 bit, instruction offered to decode.
REQ-012 SHALL have port dec_ready, input, 1 bit, decode accepts the offered instruction.
REQ-013 SHALL have port dec_instr, output, 32 bits, offered instruction.
REQ-014 SHALL have port dec_pc, output, 32 bits, byte address of dec_instr.
REQ-015 SHALL have port fetch_fault, output, 1 bit, sticky fault flag.
REQ-016 SHALL have port instr_cnt, output, 32 bits, count of accepted instructions.

Function
REQ-017 SHALL hold internal state: resp_valid, resp_pc[31:0], resp_oob (response address out of range).
REQ-018 SHALL define stall = dec_valid & ~dec_ready, and advance = fetch_en & ~stall & ~redirect_valid.
REQ-019 SHALL drive imem_freeze = ~advance combinationally.
REQ-020 SHALL, on an advance edge: resp_pc <= pc_out, resp_valid <= 1, resp_oob <= (pc_out[31:2] >= IMEM_WORDS), pc_out <= pc_out + 4 (modulo 2^32).
REQ-021 SHALL, on a redirect_valid edge, with priority over stall and fetch_en: pc_out <= {redirect_pc[31:2],2'b00}, resp_valid <= 0 (flush in-flight/held instruction).
REQ-022 SHALL set fetch_fault on a redirect whose redirect_pc[1:0] != 0.
REQ-023 SHALL, on a stall edge without redirect, hold pc_out, resp_pc, resp_valid, resp_oob unchanged; memory holds RI via imem_freeze.
REQ-024 SHALL, on an edge with fetch_en=0, no stall and no redirect, hold pc_out and clear resp_valid.
REQ-025 SHALL drive dec_valid = resp_valid and dec_pc = resp_pc.
REQ-026 SHALL drive dec_instr = 32'h00000013 (NOP) when resp_oob=1; otherwise dec_instr = RI.
REQ-027 SHALL set fetch_fault on the edge where an instruction with resp_oob=1 is accepted (dec_valid & dec_ready).
REQ-028 SHALL keep fetch_fault sticky; only reset clears it.
REQ-029 SHALL increment instr_cnt by 1 on each edge with dec_valid & dec_ready, wrapping 32'hFFFFFFFF -> 0.
REQ-030 SHALL let an accepted handshake coincident with a redirect count in instr_cnt, while the redirect still flushes the next response.
REQ-031 SHALL give a minimum latency of one cycle from pc_out issue to dec_valid; back-to-back throughput SHALL be one instruction per cycle when dec_ready=1.

Reset
REQ-032 SHALL, while zero=1 at an edge: pc_out <= RESET_PC, resp_valid <= 0, resp_oob <= 0, resp_pc <= RESET_PC, fetch_fault <= 0, instr_cnt <= 0; zero SHALL override redirect_valid and fetch_en.
REQ-033 SHALL produce the first dec_valid=1 (dec_pc=RESET_PC) one edge after zero deasserts with fetch_en=1, including when zero asserts mid-stall or mid-redirect.

Verification
REQ-034 SHALL verify streaming: zero for 2 cycles then released, fetch_en=1, dec_ready=1, IMEM holding 00438393, ffe38393, 00c40433 at words 0..2 -> dec_pc 0,4,8 with those instructions on consecutive cycles, instr_cnt=3.
REQ-035 SHALL verify stall: dec_ready=0 for 3 cycles while dec_pc=4 -> dec_instr=ffe38393 and pc_out=8 held, imem_freeze=1; after release the next dec_pc=8.
REQ-036 SHALL verify redirect: redirect_valid=1, redirect_pc=32'h20 while dec_pc=4 is stalled -> dec_valid=0 next cycle, then dec_pc=32'h20 with instruction 00438393.
REQ-037 SHALL verify misaligned redirect: redirect_pc=32'h22 -> pc_out=32'h20, fetch_fault=1 until zero.
REQ-038 SHALL verify out-of-range: fetch reaches pc 32'h30 (word 12) -> dec_instr=32'h00000013, fetch_fault=1 upon acceptance.
REQ-039 SHALL verify reset mid-operation: zero=1 during stall with instr_cnt=5 -> dec_valid=0, instr_cnt=0, pc_out=RESET_PC next edge.
